// File: rtl/scan_sequencer.sv
// ============================================================================
// Module   : scan_sequencer
// Brief    : Steps a masked set of 16 channels onto a 4-to-16 decoder select,
//            holding each for DWELL cycles. `SCAN_BLANK_EN adds a one-cycle
//            enable=0 blank between channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [15:0] mask,
    output logic [3:0]  select,
    output logic        enable,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_select;
    logic [3:0]         w_select_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [15:0]        r_mask;
    logic [15:0]        w_mask_nxt;
    logic               r_cont;
    logic               w_cont_nxt;

    logic [15:0]        w_upper;
    logic [4:0]         w_next;
    logic [4:0]         w_first;
    logic [4:0]         w_pick;
    state_t             w_adv_state;
    logic [3:0]         w_adv_select;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [4:0] f_lowest(input logic [15:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    always_comb begin
        w_upper = 16'd0;
        for (int i = 0; i < 16; i++) begin
            w_upper[i] = r_mask[i] && (4'(i) > r_select);
        end
    end

    assign w_next  = f_lowest(w_upper);
    assign w_first = f_lowest(r_mask);
    assign w_pick  = f_lowest(mask);

    // Channel-advance decision shared by GAP and, without blanking, by SCAN.
    always_comb begin
        w_adv_state  = S_DONE;
        w_adv_select = r_select;
        if (w_next[4]) begin
            w_adv_state  = S_SCAN;
            w_adv_select = w_next[3:0];
        end else if (r_cont) begin
            w_adv_state  = S_SCAN;
            w_adv_select = w_first[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_select <= 4'd0;
            r_cnt    <= '0;
            r_mask   <= 16'd0;
            r_cont   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_select <= w_select_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mask   <= w_mask_nxt;
            r_cont   <= w_cont_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_select_nxt = r_select;
        w_cnt_nxt    = r_cnt;
        w_mask_nxt   = r_mask;
        w_cont_nxt   = r_cont;
        enable       = (r_state == S_SCAN);
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        select       = r_select;

        case (r_state)
            S_IDLE: begin
                if (start && !stop && (mask != 16'd0)) begin
                    w_mask_nxt   = mask;
                    w_cont_nxt   = continuous;
                    w_select_nxt = w_pick[3:0];
                    w_cnt_nxt    = c_DWELL_M1;
                    w_state_nxt  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else begin
`ifdef SCAN_BLANK_EN
                    w_state_nxt = S_GAP;
`else
                    w_state_nxt  = w_adv_state;
                    w_select_nxt = w_adv_select;
                    w_cnt_nxt    = c_DWELL_M1;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            S_GAP: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt  = w_adv_state;
                    w_select_nxt = w_adv_select;
                    w_cnt_nxt    = c_DWELL_M1;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// ============================================================================
// Module   : tb_scan_sequencer
// Brief    : Directed self-checking bench for scan_sequencer (DWELL=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_sequencer;

    localparam int c_DWELL = 4;
`ifdef SCAN_BLANK_EN
    localparam int c_GAP = 1;
`else
    localparam int c_GAP = 0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] mask;
    logic [3:0]  select;
    logic        enable;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    scan_sequencer #(.DWELL(c_DWELL), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .mask       (mask),
        .select     (select),
        .enable     (enable),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic en, input logic [3:0] sel,
                              input logic bz, input logic dn);
        check({tag, ".enable"}, 32'(enable), 32'(en));
        check({tag, ".select"}, 32'(select), 32'(sel));
        check({tag, ".busy"},   32'(busy),   32'(bz));
        check({tag, ".done"},   32'(done),   32'(dn));
    endtask

    // Single pass; with disturb=1, start is re-asserted and mask/mode are
    // scrambled while busy, none of which may alter the pass.
    task automatic run_pass(input string tag, input logic [15:0] m, input logic disturb);
        logic [3:0] last;
        last       = 4'd0;
        mask       = m;
        continuous = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        if (disturb) begin
            mask       = 16'd0;
            continuous = 1'b1;
        end
        for (int ch = 0; ch < 16; ch++) begin
            if (m[ch]) begin
                for (int d = 0; d < c_DWELL; d++) begin
                    expect_out($sformatf("%s.ch%0d.d%0d", tag, ch, d), 1'b1, 4'(ch), 1'b1, 1'b0);
                    start = disturb;
                    tick();
                    start = 1'b0;
                end
                if (c_GAP == 1) begin
                    expect_out($sformatf("%s.gap%0d", tag, ch), 1'b0, 4'(ch), 1'b1, 1'b0);
                    tick();
                end
                last = 4'(ch);
            end
        end
        expect_out({tag, ".done"}, 1'b0, last, 1'b1, 1'b1);
        tick();
        expect_out({tag, ".idle"}, 1'b0, last, 1'b0, 1'b0);
        tick();
        expect_out({tag, ".idle2"}, 1'b0, last, 1'b0, 1'b0);
        mask       = 16'd0;
        continuous = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        mask       = 16'd0;
        tick();
        tick();
        expect_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("post_reset", 1'b0, 4'd0, 1'b0, 1'b0);

        // Single channel, continuous: re-dwells channel 5, then reset mid-scan.
        mask       = 16'h0020;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int d = 0; d < c_DWELL; d++) begin
            expect_out("solo.first", 1'b1, 4'd5, 1'b1, 1'b0);
            tick();
        end
        if (c_GAP == 1) begin
            expect_out("solo.gap", 1'b0, 4'd5, 1'b1, 1'b0);
            tick();
        end
        expect_out("solo.again", 1'b1, 4'd5, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_mid", 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        expect_out("rst_mid2", 1'b0, 4'd0, 1'b0, 1'b0);

        // start with empty mask is ignored
        mask  = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("mask0", 1'b0, 4'd0, 1'b0, 1'b0);

        // start and stop together: stop wins
        mask  = 16'hFFFF;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        expect_out("start_stop", 1'b0, 4'd0, 1'b0, 1'b0);

        run_pass("full",   16'hFFFF, 1'b0);
        run_pass("sparse", 16'h8421, 1'b1);
        run_pass("top",    16'h8000, 1'b0);
        run_pass("bottom", 16'h0001, 1'b1);

        // Continuous wrap over channels 0,1; stop on the second visit of 1.
        mask       = 16'h0003;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int v = 0; v < 3; v++) begin
            for (int d = 0; d < c_DWELL; d++) begin
                expect_out($sformatf("wrap.v%0d.d%0d", v, d), 1'b1, 4'(v % 2), 1'b1, 1'b0);
                tick();
            end
            if (c_GAP == 1) begin
                expect_out($sformatf("wrap.gap%0d", v), 1'b0, 4'(v % 2), 1'b1, 1'b0);
                tick();
            end
        end
        expect_out("wrap.ch1a", 1'b1, 4'd1, 1'b1, 1'b0);
        tick();
        expect_out("wrap.ch1b", 1'b1, 4'd1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("wrap.stopped", 1'b0, 4'd1, 1'b0, 1'b0);
        tick();
        expect_out("wrap.stopped2", 1'b0, 4'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
